mul16_seq: RTL

//   Sequential 16x16 unsigned shift-and-add multiplier for the HACK datapath.

---
 rtl/mul16_seq_pkg.sv | 17 +
 rtl/mul16_seq_if.sv | 24 ++
 rtl/mul16_seq_add16.sv | 14 +
 rtl/mul16_seq.sv | 93 +++++++++
 4 files changed

// File: rtl/mul16_seq_pkg.sv
// Shared constants and types for the sequential 16x16 multiplier.
package mul16_seq_pkg;

    localparam int WORD     = 16;
    localparam int MUL_ITER = 16;
    localparam int CNT_W    = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef struct packed {
        logic [WORD-1:0] hi;
        logic [WORD-1:0] lo;
    } product_t;

endpackage

// File: rtl/mul16_seq_if.sv
// Request/result bundle between the datapath sequencer and the multiplier.
interface mul16_seq_if;
    import mul16_seq_pkg::*;

    logic            start;
    logic [WORD-1:0] x;
    logic [WORD-1:0] y;
    logic            busy;
    logic            done;
    logic [WORD-1:0] product_lo;
    logic [WORD-1:0] product_hi;
    logic            ovf;

    modport master (
        output start, x, y,
        input  busy, done, product_lo, product_hi, ovf
    );

    modport slave (
        input  start, x, y,
        output busy, done, product_lo, product_hi, ovf
    );

endinterface

// File: rtl/mul16_seq_add16.sv
// Add16: 16-bit adder with carry-in and carry-out, the shared HACK partial-sum adder.
module mul16_seq_add16
    import mul16_seq_pkg::*;
(
    input  logic [WORD-1:0] a,
    input  logic [WORD-1:0] b,
    input  logic            cin,
    output logic [WORD-1:0] s,
    output logic            cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{WORD{1'b0}}, cin};

endmodule

// File: rtl/mul16_seq.sv
// Sequential 16x16 unsigned shift-and-add multiplier, one partial-product add per cycle.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   S_IDLE | no operation, waiting for start
//   S_RUN  | iterating, 16 cycles, busy high, start ignored
//   S_DONE | one cycle, done high, result valid, start accepted again
module mul16_seq
    import mul16_seq_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    mul16_seq_if.slave bus
);

    logic [1:0]        state;
    logic [WORD-1:0]   m;
    // The 33rd accumulator bit is zero after every shift, so only 32 bits are kept.
    logic [2*WORD-1:0] p;
    logic [CNT_W-1:0]  cnt;
    product_t          result;
    logic              ovf_q;

    logic              accept;
    logic              last;
    logic [WORD-1:0]   addend;
    logic [WORD-1:0]   sum;
    logic              carry;
    logic [2*WORD-1:0] p_next;

    assign accept = bus.start && ((state == S_IDLE) || (state == S_DONE));
    assign last   = (cnt == CNT_W'(MUL_ITER - 1));
    assign addend = p[0] ? m : '0;

    mul16_seq_add16 u_add16 (
        .a    (p[2*WORD-1:WORD]),
        .b    (addend),
        .cin  (1'b0),
        .s    (sum),
        .cout (carry)
    );

    // Carry out of the add lands in bit 31 so wide products are never truncated.
    assign p_next = {carry, sum, p[WORD-1:1]};

    // Control sequencing: accept, iterate 16 times, present result for one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:  state <= accept ? S_RUN : S_IDLE;
                S_RUN:   state <= last ? S_DONE : S_RUN;
                S_DONE:  state <= accept ? S_RUN : S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Operand capture and accumulator shift; untouched outside accept and RUN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m   <= '0;
            p   <= '0;
            cnt <= '0;
        end else if (accept) begin
            m   <= bus.x;
            p   <= {{WORD{1'b0}}, bus.y};
            cnt <= '0;
        end else if (state == S_RUN) begin
            p   <= p_next;
            cnt <= cnt + 1'b1;
        end
    end

    // Result registers change only on the final iteration edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result <= '0;
            ovf_q  <= 1'b0;
        end else if ((state == S_RUN) && last) begin
            result <= p_next;
            ovf_q  <= |p_next[2*WORD-1:WORD];
        end
    end

    assign bus.busy       = (state == S_RUN);
    assign bus.done       = (state == S_DONE);
    assign bus.product_lo = result.lo;
    assign bus.product_hi = result.hi;
    assign bus.ovf        = ovf_q;

endmodule
